ksa_swap_s_mem: RTL and testbench
=================================

Name: ksa_swap_s_mem

Overview:
- Second stage of the RC4 key-scheduling algorithm (KSA).
- Starts once the S-memory identity fill (s[i] = i) completes; its start is driven by that stage's done flag.
- Performs for i = 0..255: j = j + s[i] + key[i mod KEY_LENGTH]; swap s[i], s[j].
- Drives the single-port S memory through the top-level address/data/write-enable mux; result feeds the PRGA/decrypt stage.

Parameters:
- KEY_LENGTH, 3: secret key length in bytes.
- S_DEPTH, 256: S memory depth; fixed at 256 for RC4.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- start  input  1  level/pulse; sampled only in IDLE or DONE
- secret_key  input  8*KEY_LENGTH  key; byte k = secret_key[8*(KEY_LENGTH-k)-1 -: 8] (byte 0 is MSB)
- q_in  input  8  S memory read data, valid one cycle after address presented
- address_out  output  8  S memory address
- data_out  output  8  S memory write data
- write_enable_out  output  1  S memory write strobe
- swap_done  output  1  KSA complete

Behaviour:
- Reset (async, active-low): state=IDLE; i=0, j=0, key_idx=0; si, sj regs=0.
  - Outputs at reset: address_out=0, data_out=0, write_enable_out=0, swap_done=0.
- Memory model: synchronous read; q_in reflects the address presented on the previous cycle.
- States (one cycle each except IDLE/DONE):
  - IDLE: outputs idle (we=0). start=1 -> RD_I, with i=0, j=0, key_idx=0.
  - RD_I: address_out=i, we=0 -> LATCH_I.
  - LATCH_I: si<=q_in; j<=j+q_in+key[key_idx] (8-bit wrap, mod 256) -> RD_J.
  - RD_J: address_out=j, we=0 -> LATCH_J.
  - LATCH_J: sj<=q_in -> WR_I.
  - WR_I: address_out=i, data_out=sj, we=1 -> WR_J.
  - WR_J: address_out=j, data_out=si, we=1.
    - i==255 -> DONE.
    - Otherwise i<=i+1; key_idx<=(key_idx==KEY_LENGTH-1)?0:key_idx+1 -> RD_I.
  - DONE: swap_done=1, we=0. start=1 -> RD_I with i=j=key_idx=0; swap_done drops the next cycle.
- key_idx is a wrapping counter; no divider is used for i mod KEY_LENGTH.
- i==j: both writes target the same address with the same value (si==sj); no special handling.
- i is 8 bits; the terminal test uses i==255 (no 9-bit overflow counter).
- Latency: 6 cycles per iteration; 1536 cycles from first RD_I to DONE entry. swap_done is high on cycle 1537 after the start-sampling edge.
- write_enable_out is high only in WR_I/WR_J; never high in IDLE, DONE or read states.
- start while busy (any state other than IDLE/DONE) is ignored.
- secret_key must be stable from start until swap_done; not internally latched.
- Reset mid-operation: immediate return to IDLE with all outputs low. S memory contents are undefined; the upstream fill stage must rerun.
- Outputs are registered or decoded from state only; no combinational path from q_in to address_out.

Decomposition:
- Package rc4_pkg:
  - S_DEPTH=256, KEY_LENGTH default, byte typedef (logic [7:0]).
  - ksa_state_t enum {IDLE, RD_I, LATCH_I, RD_J, LATCH_J, WR_I, WR_J, DONE}.
- Sub-module key_byte_select (combinational mux of secret_key by key_idx). Keeps the endian rule in one place for reuse by later stages.

Test Plan:
- Bench S memory pre-filled s[i]=i, key=24'h000000, start pulse: i=2 iteration produces writes (addr 2, data 3) then (addr 3, data 2); iterations i=0,1 write the same value back (i==j); swap_done high exactly 1537 cycles after start.
- key=24'h000249, full run: final S memory matches a behavioural RC4 KSA reference model byte-for-byte. Spot-check that j after i=0 is 8'h00 and after i=1 is 8'h03.
- Reset asserted low during cycle ~700: write_enable_out=0, address_out=0, swap_done=0 immediately (asynchronous). Re-release, restart: completes in 1537 cycles with correct final S.
- start held high continuously from IDLE through the run: no restart mid-run. After DONE, start still high restarts (swap_done drops for one pass).
- Monitor checks on every cycle:
  - write_enable_out never high outside WR_I/WR_J.
  - Exactly 512 write strobes per run.
  - No write to any address before the first read of that iteration.

Source files
------------

// File: rtl/ksa_swap_s_mem_pkg.sv
// Shared types and constants for the RC4 key-scheduling (KSA) swap stage.
// State encodings are fixed numbers so the debug enum and the FSM agree.
package ksa_swap_s_mem_pkg;

  localparam int S_DEPTH            = 256;
  localparam int KEY_LENGTH_DEFAULT = 3;

  typedef logic [7:0] byte_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_I    = 3'd1;
  localparam logic [2:0] ST_LATCH_I = 3'd2;
  localparam logic [2:0] ST_RD_J    = 3'd3;
  localparam logic [2:0] ST_LATCH_J = 3'd4;
  localparam logic [2:0] ST_WR_I    = 3'd5;
  localparam logic [2:0] ST_WR_J    = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

  typedef enum logic [2:0] {
    KSA_IDLE    = 3'd0,
    KSA_RD_I    = 3'd1,
    KSA_LATCH_I = 3'd2,
    KSA_RD_J    = 3'd3,
    KSA_LATCH_J = 3'd4,
    KSA_WR_I    = 3'd5,
    KSA_WR_J    = 3'd6,
    KSA_DONE    = 3'd7
  } ksa_state_t;

endpackage

// File: rtl/ksa_swap_s_mem_if.sv
// Control and S-memory bus of the KSA swap stage; master is the KSA engine.
interface ksa_swap_s_mem_if
  import ksa_swap_s_mem_pkg::*;
#(
  parameter int KEY_LENGTH = KEY_LENGTH_DEFAULT
);

  // Handshake: start is a request level, accepted on any clock edge where the
  // engine sits in IDLE or DONE; swap_done is a completion level that stays
  // high until the next accepted start and is never asserted together with a
  // memory access. Memory side: q_in is valid one cycle after address_out.
  logic                    start;
  logic [8*KEY_LENGTH-1:0] secret_key;
  byte_t                   q_in;
  byte_t                   address_out;
  byte_t                   data_out;
  logic                    write_enable_out;
  logic                    swap_done;
  ksa_state_t              state_dbg;

  modport master (
    input  start, secret_key, q_in,
    output address_out, data_out, write_enable_out, swap_done, state_dbg
  );

  modport slave (
    output start, secret_key, q_in,
    input  address_out, data_out, write_enable_out, swap_done, state_dbg
  );

endinterface

// File: rtl/ksa_swap_s_mem_key_byte_select.sv
// Picks key byte key_idx from the packed key; byte 0 is the most significant
// byte, and this is the only place that ordering is encoded.
module ksa_swap_s_mem_key_byte_select
  import ksa_swap_s_mem_pkg::*;
#(
  parameter int KEY_LENGTH = KEY_LENGTH_DEFAULT,
  parameter int KIW        = 2
) (
  input  logic [8*KEY_LENGTH-1:0] secret_key_i,
  input  logic [KIW-1:0]          key_idx_i,
  output byte_t                   key_byte_o
);

  always_comb begin
    key_byte_o = '0;
    for (int k = 0; k < KEY_LENGTH; k++) begin
      if (key_idx_i == KIW'(k)) begin
        key_byte_o = secret_key_i[8*(KEY_LENGTH-k)-1 -: 8];
      end
    end
  end

endmodule

// File: rtl/ksa_swap_s_mem.sv
// RC4 KSA swap pass: for i = 0..255, j += s[i] + key[i mod len], swap s[i], s[j],
// using a single-port synchronous-read S memory, six cycles per iteration.
module ksa_swap_s_mem
  import ksa_swap_s_mem_pkg::*;
#(
  parameter int KEY_LENGTH = KEY_LENGTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  ksa_swap_s_mem_if.master   bus
);

  localparam int KIW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

  logic [2:0]     state_q, state_d;
  byte_t          i_q, i_d;
  byte_t          j_q, j_d;
  byte_t          si_q, si_d;
  byte_t          sj_q, sj_d;
  logic [KIW-1:0] kidx_q, kidx_d;
  byte_t          key_byte;

  ksa_swap_s_mem_key_byte_select #(
    .KEY_LENGTH (KEY_LENGTH),
    .KIW        (KIW)
  ) u_key_sel (
    .secret_key_i (bus.secret_key),
    .key_idx_i    (kidx_q),
    .key_byte_o   (key_byte)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    kidx_d  = kidx_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RD_I;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
        end
      end
      ST_RD_I:    state_d = ST_LATCH_I;
      ST_LATCH_I: begin
        si_d    = bus.q_in;
        j_d     = j_q + bus.q_in + key_byte;
        state_d = ST_RD_J;
      end
      ST_RD_J:    state_d = ST_LATCH_J;
      ST_LATCH_J: begin
        sj_d    = bus.q_in;
        state_d = ST_WR_I;
      end
      ST_WR_I:    state_d = ST_WR_J;
      ST_WR_J: begin
        if (i_q == byte_t'(S_DEPTH - 1)) begin
          state_d = ST_DONE;
        end else begin
          i_d     = i_q + 8'd1;
          // Wrapping index stands in for i mod KEY_LENGTH.
          kidx_d  = (kidx_q == KIW'(KEY_LENGTH - 1)) ? '0 : kidx_q + KIW'(1);
          state_d = ST_RD_I;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      kidx_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      kidx_q  <= kidx_d;
    end
  end

  // Outputs depend only on state and registers, never on q_in.
  byte_t addr_c, data_c;
  logic  we_c, done_c;

  always_comb begin
    addr_c = '0;
    data_c = '0;
    we_c   = 1'b0;
    done_c = 1'b0;
    case (state_q)
      ST_RD_I: addr_c = i_q;
      ST_RD_J: addr_c = j_q;
      ST_WR_I: begin
        addr_c = i_q;
        data_c = sj_q;
        we_c   = 1'b1;
      end
      ST_WR_J: begin
        addr_c = j_q;
        data_c = si_q;
        we_c   = 1'b1;
      end
      ST_DONE: done_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.address_out      = addr_c;
  assign bus.data_out         = data_c;
  assign bus.write_enable_out = we_c;
  assign bus.swap_done        = done_c;
  assign bus.state_dbg        = ksa_state_t'(state_q);

endmodule

// File: tb/tb_ksa_swap_s_mem.sv
// Directed bench for ksa_swap_s_mem: behavioural S memory, reference KSA
// model feeding an expected-write queue, cycle-by-cycle schedule checks.
module tb_ksa_swap_s_mem;
  import ksa_swap_s_mem_pkg::*;

  localparam int KL = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ksa_swap_s_mem_if #(.KEY_LENGTH(KL)) bus_if ();

  ksa_swap_s_mem #(.KEY_LENGTH(KL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // ---------------- S memory (synchronous read) ----------------
  logic [7:0] mem [256];
  logic       fill_req;

  always @(posedge clk) begin
    bus_if.q_in <= mem[bus_if.address_out];
    if (fill_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (bus_if.write_enable_out) begin
      mem[bus_if.address_out] <= bus_if.data_out;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_total = 0;
  int          n_bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_w[$];
  logic [7:0]  exp_j [256];
  logic [7:0]  obs_j [256];
  logic [7:0]  ref_s [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] kbyte(input logic [23:0] key, input int k);
    logic [23:0] sh;
    sh = key >> (8 * (2 - k));
    return sh[7:0];
  endfunction

  // Reference RC4 KSA run over the current memory contents.
  task automatic build_ref(input logic [23:0] key);
    logic [7:0] j;
    logic [7:0] t;
    j = 8'd0;
    exp_q.delete();
    for (int k = 0; k < 256; k++) ref_s[k] = mem[k];
    for (int i = 0; i < 256; i++) begin
      j = j + ref_s[i] + kbyte(key, i % 3);
      exp_j[i] = j;
      exp_q.push_back({8'(i), ref_s[j]});
      exp_q.push_back({j, ref_s[i]});
      t        = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
    end
  endtask

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic prep_identity();
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"}, bus_if.address_out, 0);
    check({tag, "_data"}, bus_if.data_out, 0);
    check({tag, "_we"},   bus_if.write_enable_out, 0);
    check({tag, "_done"}, bus_if.swap_done, 0);
  endtask

  task automatic run_ksa(input logic [23:0] key, input bit hold, input int abort_at);
    logic [15:0] w;
    logic [15:0] w_exp;
    int ph;
    int ic;
    bus_if.secret_key = key;
    build_ref(key);
    obs_w.delete();
    bus_if.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 1536; k++) begin
      @(negedge clk);
      if (!hold) bus_if.start = 1'b0;
      ph = (k - 1) % 6;
      ic = (k - 1) / 6;
      check("busy_done", bus_if.swap_done, 0);
      check($sformatf("we_phase_c%0d", k), bus_if.write_enable_out, (ph == 4 || ph == 5));
      if (ph == 0) check($sformatf("rd_i_addr_%0d", ic), bus_if.address_out, ic);
      if (ph == 2) begin
        check($sformatf("rd_j_addr_%0d", ic), bus_if.address_out, exp_j[ic]);
        obs_j[ic] = bus_if.address_out;
      end
      if (bus_if.write_enable_out) begin
        w = {bus_if.address_out, bus_if.data_out};
        obs_w.push_back(w);
        if (exp_q.size() != 0) w_exp = exp_q.pop_front();
        else                   w_exp = 16'hxxxx;
        check($sformatf("write_c%0d", k), w, w_exp);
      end
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        return;
      end
    end
    @(negedge clk);
    check("done_at_1537", bus_if.swap_done, 1);
    check("done_we", bus_if.write_enable_out, 0);
    check("done_addr", bus_if.address_out, 0);
    check("write_count", obs_w.size(), 512);
    for (int k = 0; k < 256; k++) check($sformatf("s_final_%0d", k), mem[k], ref_s[k]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset             = 1'b0;
    fill_req          = 1'b0;
    bus_if.start      = 1'b0;
    bus_if.secret_key = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle");

    // Zero key over identity: iterations 0,1 rewrite in place, i=2 swaps 2<->3.
    prep_identity();
    run_ksa(24'h000000, 1'b0, 0);
    check("k0_w0", obs_w[0], 16'h0000);
    check("k0_w1", obs_w[1], 16'h0000);
    check("k0_w2", obs_w[2], 16'h0101);
    check("k0_w3", obs_w[3], 16'h0101);
    check("k0_w4", obs_w[4], 16'h0203);
    check("k0_w5", obs_w[5], 16'h0302);
    @(negedge clk);
    check("done_holds", bus_if.swap_done, 1);
    check("done_holds_we", bus_if.write_enable_out, 0);

    // Key 00 02 49: j after i=0 is 0x00, after i=1 is 0x03.
    prep_identity();
    run_ksa(24'h000249, 1'b0, 0);
    check("j_after_i0", obs_j[0], 8'h00);
    check("j_after_i1", obs_j[1], 8'h03);

    // Reset during a write cycle mid-run, then a clean rerun.
    prep_identity();
    run_ksa(24'h000249, 1'b0, 701);
    repeat (2) @(negedge clk);
    check_idle_outputs("rst_held");
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_release");
    prep_identity();
    run_ksa(24'h000249, 1'b0, 0);

    // start held high: no restart mid-run, immediate restart from DONE.
    prep_identity();
    run_ksa(24'h000249, 1'b1, 0);
    run_ksa(24'h000249, 1'b1, 0);
    bus_if.start = 1'b0;
    @(negedge clk);
    check("hold_end_done", bus_if.swap_done, 1);
    check("hold_end_we", bus_if.write_enable_out, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
